// File: rtl/button_evt_pkg.sv
// button_evt_pkg: shared button indices, per-button repeat states and default button count.
package button_evt_pkg;
  localparam int N_BTN = 4;
  typedef enum logic [1:0] {BTN_LEFT = 2'd0, BTN_RIGHT = 2'd1, BTN_UP = 2'd2, BTN_FIRE = 2'd3} btn_id_t;
  typedef enum logic [1:0] {IDLE, DELAY, REPEAT, HELD} rpt_state_t;
endpackage

// File: rtl/button_repeat_timer.sv
// button_repeat_timer: per-button hold FSM raising auto-repeat ticks after a delay, then periodically.
module button_repeat_timer import button_evt_pkg::*; #(
  parameter int REPEAT_DELAY  = 6_300_000,
  parameter int REPEAT_PERIOD = 2_520_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic clk25,
  input  logic reset,
  input  logic btn,
  input  logic press,
  output logic fire
);
  localparam int CW = $clog2((REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD) + 1);
  rpt_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  always_ff @(posedge clk25 or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    fire    = 1'b0;
    if (!btn) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (press) state_d = REPEAT_EN ? DELAY : HELD;
        end
        DELAY:
          if (cnt_q == CW'(REPEAT_DELAY - 1)) begin
            fire    = 1'b1;
            state_d = REPEAT;
            cnt_d   = '0;
          end
        REPEAT:
          if (cnt_q == CW'(REPEAT_PERIOD - 1)) begin
            fire  = 1'b1;
            cnt_d = '0;
          end
        default: cnt_d = cnt_q;
      endcase
    end
  end
endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: turns button presses and auto-repeats into a single
// round-robin arbitrated valid/ready event stream with a lost-event counter.
module button_event_arbiter #(
  parameter int               N_BTN         = button_evt_pkg::N_BTN,
  parameter int               REPEAT_DELAY  = 6_300_000,
  parameter int               REPEAT_PERIOD = 2_520_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 4'b0111
) (
  input  logic                     clk25,
  input  logic                     reset,
  input  logic [N_BTN-1:0]         btn_stable,
  output logic                     evt_valid,
  input  logic                     evt_ready,
  output logic [$clog2(N_BTN)-1:0] evt_id,
  output logic                     evt_repeat,
  output logic [7:0]               ovf_cnt
);
  import button_evt_pkg::*;
  localparam int IW = $clog2(N_BTN);
  logic [N_BTN-1:0] prev_q, pending_q, pending_d, kind_q, kind_d, press, fire, evt, clr;
  logic [IW-1:0] rr_q, rr_d, evt_id_q, evt_id_d, gnt_idx;
  logic evt_valid_q, evt_valid_d, evt_repeat_q, evt_repeat_d, gnt_found, gnt, free;
  logic [7:0] ovf_q, ovf_d;
  assign press = btn_stable & ~prev_q;
  for (genvar g = 0; g < N_BTN; g++) begin : g_tmr
    button_repeat_timer #(
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD),
      .REPEAT_EN    (REPEAT_MASK[g])
    ) u_tmr (
      .clk25(clk25),
      .reset(reset),
      .btn  (btn_stable[g]),
      .press(press[g]),
      .fire (fire[g])
    );
  end
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int j = 0; j < N_BTN; j++)
      if (!gnt_found && pending_q[(int'(rr_q) + j) % N_BTN]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'((int'(rr_q) + j) % N_BTN);
      end
    free = !evt_valid_q || evt_ready;
    gnt  = free && gnt_found;
    clr  = gnt ? (N_BTN'(1) << gnt_idx) : '0;
    evt  = press | fire;
    // a fresh event on the button being granted stays pending
    pending_d    = (pending_q & ~clr) | evt;
    kind_d       = (kind_q & ~evt) | fire;
    ovf_d        = (|(evt & pending_q & ~clr)) && ovf_q != 8'hff ? ovf_q + 8'd1 : ovf_q;
    evt_valid_d  = gnt ? 1'b1 : free ? 1'b0 : evt_valid_q;
    evt_id_d     = gnt ? gnt_idx : evt_id_q;
    evt_repeat_d = gnt ? kind_q[gnt_idx] : evt_repeat_q;
    rr_d         = !gnt ? rr_q : gnt_idx == IW'(N_BTN - 1) ? '0 : gnt_idx + IW'(1);
  end
  always_ff @(posedge clk25 or posedge reset)
    if (reset) begin
      prev_q       <= '0;
      pending_q    <= '0;
      kind_q       <= '0;
      rr_q         <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_repeat_q <= 1'b0;
      ovf_q        <= '0;
    end else begin
      prev_q       <= btn_stable;
      pending_q    <= pending_d;
      kind_q       <= kind_d;
      rr_q         <= rr_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_repeat_q <= evt_repeat_d;
      ovf_q        <= ovf_d;
    end
  assign evt_valid  = evt_valid_q;
  assign evt_id     = evt_id_q;
  assign evt_repeat = evt_repeat_q;
  assign ovf_cnt    = ovf_q;
endmodule
